id_stage_pipe: RTL and testbench

//  Parametrised RV32I decode stage, successor to the single-issue ID block. Sits between IF and EX.

---
 rtl/id_pkg.sv | 46 ++++
 rtl/id_regfile.sv | 41 ++++
 rtl/id_stage_pipe.sv | 207 ++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared decode definitions for the RV32I decode stage: opcodes, ALU operation
// encodings, the control bundle carried to EX and the immediate format selector.
package id_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // wb = {MemtoReg, RegWrite}, m = {MemRead, MemWrite}, ex = {ALUSrc, ALUOp}
    typedef struct packed {
        logic [1:0] wb;
        logic [1:0] m;
        logic [3:0] ex;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_J
    } imm_fmt_e;

    function automatic ctrl_t mk_ctrl(input logic [1:0] wb, input logic [1:0] m,
                                      input logic alu_src, input logic [2:0] alu_op);
        ctrl_t c;
        c.wb = wb;
        c.m  = m;
        c.ex = {alu_src, alu_op};
        return c;
    endfunction

endpackage

// File: rtl/id_regfile.sv
// Integer register file, NREGS x XLEN, two combinational read ports and one write port.
// x0 always reads zero; define ID_WB_BYPASS_EN to forward a same-cycle write to the readers.
module id_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data
);

    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && wb_rd != '0) begin
            regs[wb_rd] <= wb_data;
        end
    end

`ifdef ID_WB_BYPASS_EN
    assign rs1_data = (rs1_addr == '0) ? '0 :
                      (wb_en && wb_rd == rs1_addr) ? wb_data : regs[rs1_addr];
    assign rs2_data = (rs2_addr == '0) ? '0 :
                      (wb_en && wb_rd == rs2_addr) ? wb_data : regs[rs2_addr];
`else
    assign rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
    assign rs2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];
`endif

endmodule

// File: rtl/id_stage_pipe.sv
// RV32I decode stage: decodes one instruction per cycle into a single EX-bound register,
// with load-use stall, flush and JAL/JALR redirect. Build option: ID_WB_BYPASS_EN.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_inst,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs1_data,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [XLEN-1:0] out_imm,
    output logic [AW-1:0]   out_rd,
    output logic [AW-1:0]   out_rs1,
    output logic [AW-1:0]   out_rs2,
    output logic [1:0]      out_ctrl_wb,
    output logic [1:0]      out_ctrl_m,
    output logic [3:0]      out_ctrl_ex,
    output logic            out_illegal
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [AW-1:0]   rd_idx, rs1_idx, rs2_idx;
    logic [XLEN-1:0] rs1_data, rs2_data;

    ctrl_t           ctrl;
    imm_fmt_e        imm_fmt;
    logic            illegal, use_rs1, use_rs2, is_jal, is_jalr;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_x, link_or_imm, jump_target;
    logic            stall, accept;

    assign opcode  = in_inst[6:0];
    assign funct3  = in_inst[14:12];
    assign funct7  = in_inst[31:25];
    assign rd_idx  = AW'(in_inst[11:7]);
    assign rs1_idx = AW'(in_inst[19:15]);
    assign rs2_idx = AW'(in_inst[24:20]);

    id_regfile #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) u_regfile (
        .clk      (clk),
        .reset_n  (reset_n),
        .rs1_addr (rs1_idx),
        .rs2_addr (rs2_idx),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data)
    );

    always_comb begin
        ctrl    = CTRL_NONE;
        imm_fmt = IMM_NONE;
        illegal = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        is_jal  = 1'b0;
        is_jalr = 1'b0;
        case (opcode)
            OP_R: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                case ({funct7, funct3})
                    {7'b0000000, 3'b000}: ctrl = mk_ctrl(2'b01, 2'b00, 1'b0, ALU_ADD);
                    {7'b0100000, 3'b000}: ctrl = mk_ctrl(2'b01, 2'b00, 1'b0, ALU_SUB);
                    {7'b0000000, 3'b001}: ctrl = mk_ctrl(2'b01, 2'b00, 1'b0, ALU_SLL);
                    {7'b0000000, 3'b010}: ctrl = mk_ctrl(2'b01, 2'b00, 1'b0, ALU_SLT);
                    {7'b0000000, 3'b111}: ctrl = mk_ctrl(2'b01, 2'b00, 1'b0, ALU_AND);
                    {7'b0000000, 3'b110}: ctrl = mk_ctrl(2'b01, 2'b00, 1'b0, ALU_OR);
                    default:              illegal = 1'b1;
                endcase
            end
            OP_IMM: begin
                illegal = (funct3 != 3'b000);
                use_rs1 = 1'b1;
                imm_fmt = IMM_I;
                ctrl    = mk_ctrl(2'b01, 2'b00, 1'b1, ALU_ADD);
            end
            OP_LOAD: begin
                illegal = (funct3 != 3'b010);
                use_rs1 = 1'b1;
                imm_fmt = IMM_I;
                ctrl    = mk_ctrl(2'b11, 2'b10, 1'b1, ALU_ADD);
            end
            OP_STORE: begin
                illegal = (funct3 != 3'b010);
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm_fmt = IMM_S;
                ctrl    = mk_ctrl(2'b00, 2'b01, 1'b1, ALU_ADD);
            end
            OP_BRANCH: begin
                illegal = !(funct3 inside {3'b000, 3'b001, 3'b100, 3'b101});
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm_fmt = IMM_B;
                ctrl    = mk_ctrl(2'b00, 2'b00, 1'b0, ALU_SUB);
            end
            OP_JAL: begin
                is_jal  = 1'b1;
                imm_fmt = IMM_J;
                ctrl    = mk_ctrl(2'b01, 2'b00, 1'b1, ALU_ADD);
            end
            OP_JALR: begin
                illegal = (funct3 != 3'b000);
                is_jalr = 1'b1;
                use_rs1 = 1'b1;
                imm_fmt = IMM_I;
                ctrl    = mk_ctrl(2'b01, 2'b00, 1'b1, ALU_ADD);
            end
            default: illegal = 1'b1;
        endcase
        // An illegal word must not look like a real op to EX or to the hazard check.
        if (illegal) begin
            ctrl    = CTRL_NONE;
            imm_fmt = IMM_NONE;
            use_rs1 = 1'b0;
            use_rs2 = 1'b0;
            is_jal  = 1'b0;
            is_jalr = 1'b0;
        end
    end

    always_comb begin
        case (imm_fmt)
            IMM_I:   imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            IMM_S:   imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            IMM_B:   imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                              in_inst[30:25], in_inst[11:8], 1'b0};
            IMM_J:   imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                              in_inst[20], in_inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm_x       = XLEN'($signed(imm32));
    assign link_or_imm = (is_jal || is_jalr) ? XLEN'(4) : imm_x;
    assign jump_target = (is_jalr ? (rs1_data + imm_x) : (in_pc + imm_x)) & ~XLEN'(1);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // ready never depends on valid, and a held op stays unchanged until out_ready.
    assign stall    = out_valid && out_ctrl_m[1] && (out_rd != '0) &&
                      ((use_rs1 && rs1_idx == out_rd) || (use_rs2 && rs2_idx == out_rd));
    assign in_ready = (!out_valid || out_ready) && !stall && !flush;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            out_valid      <= 1'b0;
            out_pc         <= '0;
            out_rs1_data   <= '0;
            out_rs2_data   <= '0;
            out_imm        <= '0;
            out_rd         <= '0;
            out_rs1        <= '0;
            out_rs2        <= '0;
            out_ctrl_wb    <= '0;
            out_ctrl_m     <= '0;
            out_ctrl_ex    <= '0;
            out_illegal    <= 1'b0;
        end else begin
            redirect_valid <= accept && (is_jal || is_jalr);
            if (accept && (is_jal || is_jalr)) begin
                redirect_pc <= jump_target;
            end
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid    <= 1'b1;
                out_pc       <= in_pc;
                out_rs1_data <= rs1_data;
                out_rs2_data <= rs2_data;
                out_imm      <= link_or_imm;
                out_rd       <= rd_idx;
                out_rs1      <= rs1_idx;
                out_rs2      <= rs2_idx;
                out_ctrl_wb  <= ctrl.wb;
                out_ctrl_m   <= ctrl.m;
                out_ctrl_ex  <= ctrl.ex;
                out_illegal  <= illegal;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed scenarios followed by random traffic, all checked
// against an instruction-level reference model (mnemonic table, register array, target queue).
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        reset_n, in_valid, in_ready, flush, wb_en, out_ready;
    logic [31:0] in_pc, in_inst, wb_data;
    logic [4:0]  wb_rd;
    logic        redirect_valid, out_valid, out_illegal;
    logic [31:0] redirect_pc, out_pc, out_rs1_data, out_rs2_data, out_imm;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [1:0]  out_ctrl_wb, out_ctrl_m;
    logic [3:0]  out_ctrl_ex;

    id_stage_pipe #(.XLEN(32), .NREGS(32), .AW(5)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd),
        .wb_data(wb_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_ctrl_wb(out_ctrl_wb),
        .out_ctrl_m(out_ctrl_m), .out_ctrl_ex(out_ctrl_ex), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

`ifdef ID_WB_BYPASS_EN
    localparam logic [31:0] T4_EXP = 32'hDEAD;
`else
    localparam logic [31:0] T4_EXP = 32'h0;
`endif

    typedef enum int {
        K_ADD, K_SUB, K_SLL, K_SLT, K_AND, K_OR, K_ADDI, K_LW, K_SW,
        K_BEQ, K_BNE, K_BLT, K_BGE, K_JAL, K_JALR, K_ILL, K_ILL_R, K_ILL_B
    } kind_e;

    typedef struct packed {
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rd, rs1, rs2;
        logic [1:0]  wb, m;
        logic [3:0]  ex;
        logic        ill;
    } op_t;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_regs [32];
    logic        m_valid, m_rv;
    op_t         m_op;
    kind_e       cur_kind;
    logic [31:0] cur_imm;
    logic        obs_ready;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] encode(kind_e k, logic [4:0] rd, logic [4:0] rs1,
                                           logic [4:0] rs2, logic [31:0] imm);
        case (k)
            K_ADD:   return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
            K_SUB:   return {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
            K_SLL:   return {7'b0000000, rs2, rs1, 3'b001, rd, 7'b0110011};
            K_SLT:   return {7'b0000000, rs2, rs1, 3'b010, rd, 7'b0110011};
            K_AND:   return {7'b0000000, rs2, rs1, 3'b111, rd, 7'b0110011};
            K_OR:    return {7'b0000000, rs2, rs1, 3'b110, rd, 7'b0110011};
            K_ADDI:  return {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
            K_LW:    return {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
            K_SW:    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            K_BEQ:   return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
            K_BNE:   return {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], 7'b1100011};
            K_BLT:   return {imm[12], imm[10:5], rs2, rs1, 3'b100, imm[4:1], imm[11], 7'b1100011};
            K_BGE:   return {imm[12], imm[10:5], rs2, rs1, 3'b101, imm[4:1], imm[11], 7'b1100011};
            K_JAL:   return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
            K_JALR:  return {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
            K_ILL_R: return {7'b0000001, rs2, rs1, 3'b000, rd, 7'b0110011};
            K_ILL_B: return {7'b0000000, rs2, rs1, 3'b110, rd, 7'b1100011};
            default: return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b1111111};
        endcase
    endfunction

    function automatic logic uses_rs1(kind_e k);
        return !(k inside {K_JAL, K_ILL, K_ILL_R, K_ILL_B});
    endfunction

    function automatic logic uses_rs2(kind_e k);
        return k inside {K_ADD, K_SUB, K_SLL, K_SLT, K_AND, K_OR, K_SW,
                         K_BEQ, K_BNE, K_BLT, K_BGE};
    endfunction

    function automatic logic [31:0] read_reg(logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
`ifdef ID_WB_BYPASS_EN
        if (wb_en && wb_rd == idx) return wb_data;
`endif
        return m_regs[idx];
    endfunction

    function automatic op_t expect_op(kind_e k, logic [31:0] inst, logic [31:0] pc,
                                      logic [31:0] imm, logic [31:0] r1, logic [31:0] r2);
        op_t o;
        o = '0;
        o.pc = pc; o.rs1d = r1; o.rs2d = r2;
        o.rd = inst[11:7]; o.rs1 = inst[19:15]; o.rs2 = inst[24:20];
        case (k)
            K_ADD:  begin o.wb = 2'b01; o.ex = 4'b0000; end
            K_SUB:  begin o.wb = 2'b01; o.ex = 4'b0001; end
            K_AND:  begin o.wb = 2'b01; o.ex = 4'b0010; end
            K_OR:   begin o.wb = 2'b01; o.ex = 4'b0011; end
            K_SLL:  begin o.wb = 2'b01; o.ex = 4'b0100; end
            K_SLT:  begin o.wb = 2'b01; o.ex = 4'b0101; end
            K_ADDI: begin o.wb = 2'b01; o.ex = 4'b1000; o.imm = imm; end
            K_LW:   begin o.wb = 2'b11; o.m = 2'b10; o.ex = 4'b1000; o.imm = imm; end
            K_SW:   begin o.m = 2'b01; o.ex = 4'b1000; o.imm = imm; end
            K_BEQ, K_BNE, K_BLT, K_BGE: begin o.ex = 4'b0001; o.imm = imm; end
            K_JAL, K_JALR: begin o.wb = 2'b01; o.ex = 4'b1000; o.imm = 32'd4; end
            default: o.ill = 1'b1;
        endcase
        return o;
    endfunction

    task automatic set_inst(kind_e k, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                            logic [31:0] imm, logic [31:0] pc);
        cur_kind = k;
        cur_imm  = imm;
        in_pc    = pc;
        in_inst  = encode(k, rd, rs1, rs2, imm);
    endtask

    task automatic rand_inst();
        kind_e       k;
        logic [31:0] r, imm;
        k = kind_e'($urandom_range(0, int'(K_ILL_B)));
        r = $urandom;
        if (k inside {K_BEQ, K_BNE, K_BLT, K_BGE})
            imm = {{19{r[11]}}, r[11:0], 1'b0};
        else if (k == K_JAL)
            imm = {{11{r[19]}}, r[19:0], 1'b0};
        else
            imm = {{20{r[11]}}, r[11:0]};
        set_inst(k, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), imm, $urandom & 32'hFFFF_FFFC);
    endtask

    // One clock: inputs are set by the caller at the falling edge.
    task automatic step();
        logic        stall, exp_ready, acc;
        logic [31:0] tgt, got_t;
        op_t         nxt;
        #1;
        stall = m_valid && m_op.m[1] && m_op.rd != 5'd0 &&
                ((uses_rs1(cur_kind) && in_inst[19:15] == m_op.rd) ||
                 (uses_rs2(cur_kind) && in_inst[24:20] == m_op.rd));
        exp_ready = (!m_valid || out_ready) && !stall && !flush;
        obs_ready = in_ready;
        if (reset_n) check("in_ready", in_ready, exp_ready);
        acc = in_valid && exp_ready;
        nxt = expect_op(cur_kind, in_inst, in_pc, cur_imm,
                        read_reg(in_inst[19:15]), read_reg(in_inst[24:20]));
        tgt = (cur_kind == K_JAL) ? in_pc + cur_imm
                                  : (read_reg(in_inst[19:15]) + cur_imm) & 32'hFFFF_FFFE;
        @(posedge clk);
        if (!reset_n) begin
            m_valid = 1'b0; m_rv = 1'b0; m_op = '0;
            foreach (m_regs[i]) m_regs[i] = 32'h0;
            exp_q.delete();
        end else begin
            m_rv = 1'b0;
            if (flush) m_valid = 1'b0;
            else if (acc) begin
                m_valid = 1'b1;
                m_op = nxt;
                if (cur_kind inside {K_JAL, K_JALR}) begin
                    m_rv = 1'b1;
                    exp_q.push_back(tgt);
                end
            end else if (out_ready) m_valid = 1'b0;
            if (wb_en && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
        end
        #1;
        check("out_valid", out_valid, m_valid);
        check("redirect_valid", redirect_valid, m_rv);
        if (m_rv && exp_q.size() > 0) begin
            got_t = exp_q.pop_front();
            check("redirect_pc", redirect_pc, got_t);
        end
        if (m_valid) begin
            check("out_pc", out_pc, m_op.pc);
            check("out_rs1_data", out_rs1_data, m_op.rs1d);
            check("out_rs2_data", out_rs2_data, m_op.rs2d);
            check("out_imm", out_imm, m_op.imm);
            check("out_idx", {out_rd, out_rs1, out_rs2}, {m_op.rd, m_op.rs1, m_op.rs2});
            check("out_ctrl", {out_ctrl_wb, out_ctrl_m, out_ctrl_ex, out_illegal},
                  {m_op.wb, m_op.m, m_op.ex, m_op.ill});
        end
        @(negedge clk);
    endtask

    task automatic check_reset_zero(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_redirect"}, {redirect_valid, redirect_pc}, 0);
        check({tag, "_data"}, {out_pc, out_rs1_data}, 0);
        check({tag, "_data2"}, {out_rs2_data, out_imm}, 0);
        check({tag, "_fields"}, {out_rd, out_rs1, out_rs2, out_ctrl_wb, out_ctrl_m,
                                 out_ctrl_ex, out_illegal}, 0);
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0;
        wb_rd = 5'd0; wb_data = 32'h0; out_ready = 1'b1;
        set_inst(K_ADDI, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
        @(negedge clk);
        step();
        step();
        reset_n = 1'b1;
        check_reset_zero("rst");
        check("rst_in_ready", in_ready, 1);

        // ADDI x1,x0,-5 at 0x100
        in_valid = 1'b1;
        set_inst(K_ADDI, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFB, 32'h100);
        step();
        check("t1_imm", out_imm, 32'hFFFF_FFFB);
        check("t1_rd", out_rd, 5'd1);
        check("t1_ctrl", {out_ctrl_wb, out_ctrl_m, out_ctrl_ex}, 8'b01_00_1000);

        // load-use: LW x2,0(x1) then ADD x3,x2,x2
        set_inst(K_LW, 5'd2, 5'd1, 5'd0, 32'h0, 32'h104);
        step();
        set_inst(K_ADD, 5'd3, 5'd2, 5'd2, 32'h0, 32'h108);
        step();
        check("t2_stall_ready", obs_ready, 0);
        check("t2_bubble", out_valid, 0);
        step();
        check("t2_add_ready", obs_ready, 1);
        check("t2_add_emit", {out_valid, out_rd, out_pc}, {1'b1, 5'd3, 32'h108});

        // JAL x1,+0x20 at 0x200
        set_inst(K_JAL, 5'd1, 5'd0, 5'd0, 32'h20, 32'h200);
        step();
        check("t3_redirect", {redirect_valid, redirect_pc}, {1'b1, 32'h220});
        check("t3_link_imm", out_imm, 32'd4);
        in_valid = 1'b0;
        step();
        check("t3_pulse_end", redirect_valid, 0);

        // WB x5 in the same cycle as ADD x6,x5,x0
        in_valid = 1'b1; wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD;
        set_inst(K_ADD, 5'd6, 5'd5, 5'd0, 32'h0, 32'h300);
        step();
        check("t4_same_cycle", out_rs1_data, T4_EXP);
        wb_en = 1'b0;
        set_inst(K_ADD, 5'd7, 5'd5, 5'd0, 32'h0, 32'h304);
        step();
        check("t4_next_cycle", out_rs1_data, 32'hDEAD);

        // backpressure for three cycles, then flush
        set_inst(K_ADDI, 5'd9, 5'd0, 5'd0, 32'h123, 32'h400);
        step();
        out_ready = 1'b0;
        set_inst(K_ADDI, 5'd10, 5'd0, 5'd0, 32'h7, 32'h404);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_ready_low", obs_ready, 0);
            check("t5_held", {out_valid, out_imm, out_pc}, {1'b1, 32'h123, 32'h400});
        end
        flush = 1'b1;
        step();
        check("t5_flush", out_valid, 0);
        flush = 1'b0; out_ready = 1'b1;

        // illegal opcode, x0 write, reset during a stall
        set_inst(K_ILL, 5'd11, 5'd3, 5'd4, 32'h0, 32'h500);
        step();
        check("t6_illegal", {out_illegal, out_ctrl_wb, out_ctrl_m, out_ctrl_ex}, 9'b1_00_00_0000);
        in_valid = 1'b0; wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF;
        step();
        wb_en = 1'b0; in_valid = 1'b1;
        set_inst(K_ADD, 5'd8, 5'd0, 5'd0, 32'h0, 32'h504);
        step();
        check("t6_x0", out_rs1_data, 0);
        set_inst(K_LW, 5'd2, 5'd1, 5'd0, 32'h0, 32'h508);
        step();
        set_inst(K_ADD, 5'd3, 5'd2, 5'd2, 32'h0, 32'h50C);
        out_ready = 1'b0;
        step();
        check("t6_stalled", obs_ready, 0);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1; out_ready = 1'b1;
        check_reset_zero("t6_rst");
        set_inst(K_ADD, 5'd3, 5'd5, 5'd7, 32'h0, 32'h600);
        step();
        check("t6_reg_cleared", out_rs1_data, 0);

        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            wb_en     = $urandom_range(0, 1) == 1;
            wb_rd     = 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            rand_inst();
            step();
        end

        check("redirect_q_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
